conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
- Processing-side engine between the processing buffer and the frame buffer inside the memory controller.
- On each start pulse it walks one frame in raster order and issues a window read per pixel on raddr_alu.
- It receives a packed 3x3 RGB444 window on rdata_alu and applies a 3x3 kernel chosen from an internal 4-entry ROM.
- It writes the filtered pixel back through waddr_alu/wdata_alu/wen_alu. Fully pipelined: one pixel per cycle.

Parameters:
- DW, 12, pixel width, packed RGB444: R[11:8], G[7:4], B[3:0]
- IMG_W, 320, frame width in pixels
- IMG_H, 240, frame height in pixels
- AW, 17, address width of raddr_alu/waddr_alu; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
- sys_clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle frame start request
- kernel_sel  in  2  kernel select: 0 identity, 1 gaussian, 2 sharpen, 3 edge
- pass_thru  in  1  when high, every pixel is written unchanged
- hold  in  1  pipeline freeze request (buffer not ready)
- raddr_alu  out  AW  window-centre read address
- rdata_alu  in  9*DW  3x3 window; tap k=3*row+col (row 0 = top) at bits [k*DW +: DW]
- waddr_alu  out  AW  write address
- wdata_alu  out  DW  filtered pixel
- wen_alu  out  1  write enable
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last write of a frame

Behaviour:
- Clock, reset and single clock domain: one clock (sys_clk); reset (rst) is asynchronous and active-high.
- Reset values: raddr_alu=0, waddr_alu=0, wdata_alu=0, wen_alu=0, busy=0, done=0. The FSM goes to IDLE and all pipeline valids clear.
- Reset mid-frame: the frame is abandoned; no further writes until the next start.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. kernel_sel and pass_thru are latched at this point and held for the whole frame. busy=1 from the next cycle.
  - RUN issues one address per non-held cycle. x and y are incremental counters (no multiplier); addr = y*IMG_W + x. At x=IMG_W-1, x wraps to 0 and y increments.
  - After issuing address IMG_W*IMG_H-1, RUN -> DRAIN.
  - DRAIN -> IDLE when the pipeline is empty. done pulses in the cycle after the final wen_alu. busy drops together with done.
  - start while busy=1 is ignored.
- Pipeline and latency (no hold):
  - S0: raddr_alu presented.
  - S1: rdata_alu valid, because the memory read is synchronous with 1-cycle latency.
  - S2: the 27 per-channel products are registered.
  - S3: sum, shift and clamp are registered; wen_alu=1, waddr_alu = the address issued 3 cycles earlier.
  - Issue-to-write latency is 3 cycles.
- Hold:
  - While hold=1, no stage advances and the x/y counters freeze.
  - wen_alu is 0 for every cycle in which hold=1.
  - A write pending in S3 is issued on the first cycle after hold falls.
  - hold in IDLE has no effect.
- Kernel ROM (signed 4-bit weights, then right-shift):
  - id: 0 0 0 / 0 1 0 / 0 0 0, shift 0
  - gaussian: 1 2 1 / 2 4 2 / 1 2 1, shift 4
  - sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0
  - edge: -1 -1 -1 / -1 8 -1 / -1 -1 -1, shift 0
- Arithmetic, per channel:
  - Product: unsigned 4-bit sample × signed 4-bit weight gives a signed 9-bit product.
  - Sum of the 9 products is signed 13-bit.
  - Arithmetic right shift by the kernel's shift amount.
  - Clamp to 0..15.
- Border handling: pixels with x=0, x=IMG_W-1, y=0 or y=IMG_H-1 write the centre tap (tap 4) unchanged. pass_thru=1 does the same for all pixels.

Optional Feature:
- Macro: CONV_ABS_EN.
- Defined: a negative shifted sum is replaced by its absolute value before clamping, giving magnitude edge detection.
- Undefined: negative sums clamp to 0.

Test Plan:
- Reset: assert rst mid-frame with IMG_W=4, IMG_H=3 -> all outputs 0 asynchronously, busy=0, no wen_alu until the next start.
- Identity frame: kernel_sel=0, IMG 4x3, window taps = address-derived values -> 12 writes to addresses 0..11 in order, each wdata = tap 4; first wen 3 cycles after first raddr; done one cycle after the write to address 11.
- Gaussian: uniform window 0x888, interior pixel -> wdata=0x888.
- Sharpen clamp: centre 0xFFF, neighbours 0x000, interior pixel -> 0xFFF.
- Edge: centre 0x000, neighbours 0xFFF -> 0x000 without CONV_ABS_EN; 0xFFF with CONV_ABS_EN defined. Border pixel with the same window -> 0x000 (centre passthrough).
- Hold and start-while-busy: hold=1 for 5 cycles mid-frame -> wen_alu=0 throughout, no address skipped or duplicated, total writes = 12. A start pulse during busy -> ignored, exactly one done.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer
// ---------------------------------------------------------------------------
// Walks one frame in raster order per start pulse. For every pixel it issues
// the window-centre address on raddr_alu, receives a packed 3x3 RGB444 window
// on rdata_alu one cycle later, and convolves it with one of four ROM kernels.
// It writes the filtered pixel back on waddr_alu/wdata_alu/wen_alu. Throughput
// is one pixel per cycle; issue-to-write latency is 3 cycles.
//
// Optional build macro:
//   CONV_ABS_EN  defined   : a negative shifted sum is replaced by its magnitude
//                            before clamping (magnitude edge detection).
//                undefined : negative sums clamp to 0.
//
// Ports:
//   sys_clk      in   system clock
//   rst          in   asynchronous active-high reset
//   start        in   single-cycle frame start request (ignored while busy)
//   kernel_sel   in   0 identity, 1 gaussian, 2 sharpen, 3 edge (latched at start)
//   pass_thru    in   write every pixel unchanged (latched at start)
//   hold         in   pipeline freeze request
//   raddr_alu    out  window-centre read address
//   rdata_alu    in   3x3 window, tap k=3*row+col at bits [k*DW +: DW]
//   waddr_alu    out  write address
//   wdata_alu    out  filtered pixel
//   wen_alu      out  write enable
//   busy         out  frame in progress
//   done         out  one-cycle pulse after the last write of a frame
//   o_dbg_state  out  FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Flow control: hold is a stall. While hold=1 no pipeline stage and no
// address counter advances, and wen_alu is forced low in that same cycle; a
// write parked in the output stage is issued on the first cycle hold is low.
// The read memory keeps sampling raddr_alu during a stall, so the window
// belonging to the stage-1 pixel is captured on the first held cycle and
// replayed when the pipeline resumes.
// ---------------------------------------------------------------------------
module conv_sequencer #(
  parameter int DW    = 12,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW    = 17
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      kernel_sel,
  input  logic            pass_thru,
  input  logic            hold,
  output logic [AW-1:0]   raddr_alu,
  input  logic [9*DW-1:0] rdata_alu,
  output logic [AW-1:0]   waddr_alu,
  output logic [DW-1:0]   wdata_alu,
  output logic            wen_alu,
  output logic            busy,
  output logic            done,
  output logic [1:0]      o_dbg_state
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ksel;
  logic              r_pass;
  logic              r_busy;
  logic              r_done;

  // S0: address issue
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [AW-1:0]     r_raddr;
  logic              r_v0;

  // S1: window arriving from memory
  logic              r_v1;
  logic [AW-1:0]     r_a1;
  logic              r_byp1;
  logic [9*DW-1:0]   r_win_hold;
  logic              r_use_hold;

  // S2: registered products
  logic              r_v2;
  logic [AW-1:0]     r_a2;
  logic              r_byp2;
  logic [DW-1:0]     r_ctr2;
  logic signed [8:0] r_prod [27];

  // S3: output
  logic              r_v3;
  logic [AW-1:0]     r_waddr;
  logic [DW-1:0]     r_wdata;

  logic              w_border0;
  logic [9*DW-1:0]   w_win;
  logic signed [8:0] w_prod [27];
  logic [2:0]        w_shift;
  logic [DW-1:0]     w_pix;

  // Kernel ROM. Weights are held in 5 bits because the edge kernel's centre
  // weight of +8 does not fit a signed 4-bit field.
  function automatic logic signed [4:0] kern_w(input logic [1:0] sel, input int k);
    logic signed [4:0] w;
    w = 5'sd0;
    case (sel)
      2'd0:    w = (k == 4) ? 5'sd1 : 5'sd0;
      2'd1:    w = (k == 4) ? 5'sd4 : ((k % 2) == 1) ? 5'sd2 : 5'sd1;
      2'd2:    w = (k == 4) ? 5'sd5 : ((k % 2) == 1) ? -5'sd1 : 5'sd0;
      default: w = (k == 4) ? 5'sd8 : -5'sd1;
    endcase
    return w;
  endfunction

  assign w_border0 = (r_x == '0) || (r_x == X_LAST) || (r_y == '0) || (r_y == Y_LAST);
  assign w_win     = r_use_hold ? r_win_hold : rdata_alu;
  assign w_shift   = (r_ksel == 2'd1) ? 3'd4 : 3'd0;

  // S1 -> S2: 27 products, unsigned 4-bit sample times signed weight.
  always_comb begin
    logic signed [8:0] smp9;
    logic signed [8:0] wt9;
    logic signed [4:0] wt;
    smp9 = '0;
    wt9  = '0;
    wt   = '0;
    for (int i = 0; i < 27; i++) w_prod[i] = '0;
    for (int k = 0; k < 9; k++) begin
      wt  = kern_w(r_ksel, k);
      wt9 = $signed({{4{wt[4]}}, wt});
      for (int c = 0; c < 3; c++) begin
        smp9 = $signed({5'b0, w_win[k*DW + c*4 +: 4]});
        w_prod[k*3 + c] = smp9 * wt9;
      end
    end
  end

  // S2 -> S3: per-channel sum, arithmetic shift, optional magnitude, clamp.
  always_comb begin
    logic signed [12:0] acc;
    logic signed [12:0] shf;
    acc   = '0;
    shf   = '0;
    w_pix = '0;
    for (int c = 0; c < 3; c++) begin
      acc = '0;
      for (int k = 0; k < 9; k++) begin
        acc = acc + $signed({{4{r_prod[k*3 + c][8]}}, r_prod[k*3 + c]});
      end
      shf = acc >>> w_shift;
`ifdef CONV_ABS_EN
      if (shf < 13'sd0) shf = -shf;
`endif
      if (shf < 13'sd0)       w_pix[c*4 +: 4] = 4'd0;
      else if (shf > 13'sd15) w_pix[c*4 +: 4] = 4'd15;
      else                    w_pix[c*4 +: 4] = shf[3:0];
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ksel     <= '0;
      r_pass     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_raddr    <= '0;
      r_v0       <= 1'b0;
      r_v1       <= 1'b0;
      r_a1       <= '0;
      r_byp1     <= 1'b0;
      r_win_hold <= '0;
      r_use_hold <= 1'b0;
      r_v2       <= 1'b0;
      r_a2       <= '0;
      r_byp2     <= 1'b0;
      r_ctr2     <= '0;
      for (int i = 0; i < 27; i++) r_prod[i] <= '0;
      r_v3       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_done <= 1'b0;

      // First held cycle: keep the window that belongs to the S1 pixel.
      if (hold && r_v1 && !r_use_hold) begin
        r_win_hold <= rdata_alu;
        r_use_hold <= 1'b1;
      end

      if (!hold) begin
        r_use_hold <= 1'b0;
        r_v3 <= r_v2;
        if (r_v2) begin
          r_waddr <= r_a2;
          r_wdata <= r_byp2 ? r_ctr2 : w_pix;
        end
        r_v2 <= r_v1;
        if (r_v1) begin
          r_a2   <= r_a1;
          r_byp2 <= r_byp1;
          r_ctr2 <= w_win[4*DW +: DW];
          for (int i = 0; i < 27; i++) r_prod[i] <= w_prod[i];
        end
        r_v1 <= r_v0;
        if (r_v0) begin
          r_a1   <= r_raddr;
          r_byp1 <= r_pass | w_border0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_ksel  <= kernel_sel;
            r_pass  <= pass_thru;
            r_x     <= '0;
            r_y     <= '0;
            r_raddr <= '0;
            r_v0    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            if (r_raddr == LAST_ADDR) begin
              r_v0    <= 1'b0;
              r_state <= ST_DRAIN;
            end else begin
              r_raddr <= r_raddr + 1'b1;
              if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          // Only one frame is ever in flight, so the last address leaving
          // the output stage marks an empty pipeline.
          if (!hold && r_v3 && (r_waddr == LAST_ADDR)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign raddr_alu   = r_raddr;
  assign waddr_alu   = r_waddr;
  assign wdata_alu   = r_wdata;
  assign wen_alu     = r_v3 & ~hold;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer on a 4x3 frame. A synchronous window
// memory answers raddr_alu one cycle later; a monitor logs every write and
// every done pulse; the main sequence runs frames and compares against
// hand-computed pixels.
module tb_conv_sequencer;

  localparam int DW    = 12;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int AW    = 17;
  localparam int NPIX  = IMG_W * IMG_H;

`ifdef CONV_ABS_EN
  localparam logic [11:0] EDGE_INT  = 12'hFFF;
  localparam logic [11:0] SHARP_NEG = 12'h72B;
`else
  localparam logic [11:0] EDGE_INT  = 12'h000;
  localparam logic [11:0] SHARP_NEG = 12'h02B;
`endif

  // clock / reset
  logic            sys_clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      kernel_sel = 2'd0;
  logic            pass_thru = 1'b0;
  logic            hold = 1'b0;
  logic [AW-1:0]   raddr_alu;
  logic [9*DW-1:0] rdata_alu;
  logic [AW-1:0]   waddr_alu;
  logic [DW-1:0]   wdata_alu;
  logic            wen_alu;
  logic            busy;
  logic            done;
  logic [1:0]      o_dbg_state;

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  conv_sequencer #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .kernel_sel(kernel_sel),
    .pass_thru(pass_thru), .hold(hold), .raddr_alu(raddr_alu),
    .rdata_alu(rdata_alu), .waddr_alu(waddr_alu), .wdata_alu(wdata_alu),
    .wen_alu(wen_alu), .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  // window memory: mode 0 = address-derived taps, mode 1 = centre/neighbour
  int          win_mode = 0;
  logic [11:0] win_c = 12'h000;
  logic [11:0] win_n = 12'h000;

  function automatic logic [11:0] win_tap(input logic [AW-1:0] a, input int k);
    if (win_mode == 0) return {a[3:0], 4'(k), a[3:0] ^ 4'hA};
    return (k == 4) ? win_c : win_n;
  endfunction

  always @(posedge sys_clk) begin
    for (int k = 0; k < 9; k++) rdata_alu[k*DW +: DW] <= win_tap(raddr_alu, k);
  end

  // scoreboard
  logic [11:0]   exp_q[$];
  logic [AW-1:0] wa_q[$];
  logic [11:0]   wd_q[$];
  int            wc_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            total = 0;
  int            bad = 0;

  always @(negedge sys_clk) begin
    #2;
    if (wen_alu === 1'b1) begin
      wa_q.push_back(waddr_alu);
      wd_q.push_back(wdata_alu);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
  endtask

  task automatic build_exp(input logic [11:0] ival, input logic [11:0] bval);
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) begin
      int x;
      int y;
      x = a % IMG_W;
      y = a / IMG_W;
      if (x == 0 || x == IMG_W-1 || y == 0 || y == IMG_H-1) exp_q.push_back(bval);
      else exp_q.push_back(ival);
    end
  endtask

  task automatic build_exp_id();
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) exp_q.push_back(win_tap(AW'(a), 4));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_low_with_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_write_count"}, 32'(wa_q.size()), 32'(NPIX));
    for (int i = 0; i < wa_q.size() && i < NPIX; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input string tag, input logic [1:0] ks, input logic pt,
                           input logic [11:0] c, input logic [11:0] n,
                           input logic [11:0] ival, input logic [11:0] bval);
    win_mode = 1;
    win_c = c;
    win_n = n;
    if (pt) build_exp(c, c);
    else build_exp(ival, bval);
    clear_mon();
    @(negedge sys_clk);
    kernel_sel = ks;
    pass_thru = pt;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    // flip the selects mid-frame: the latched copies must be used
    kernel_sel = ~ks;
    pass_thru = ~pt;
    #1;
    wait_done(tag, 60);
    @(negedge sys_clk);
    #1;
    chk({tag, "_done_pulse_ends"}, 32'(done), 32'd0);
    check_writes(tag);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    int issue_cyc;
    logic [AW-1:0] h;

    // power-on reset
    #1 rst = 1'b1;
    tick(3);
    #1;
    chk("rst_raddr", 32'(raddr_alu), 32'd0);
    chk("rst_waddr", 32'(waddr_alu), 32'd0);
    chk("rst_wdata", 32'(wdata_alu), 32'd0);
    chk("rst_wen", 32'(wen_alu), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    tick(2);

    // identity frame with latency checks
    win_mode = 0;
    build_exp_id();
    clear_mon();
    @(negedge sys_clk);
    kernel_sel = 2'd0;
    pass_thru = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    #1;
    chk("id_first_raddr", 32'(raddr_alu), 32'd0);
    chk("id_busy", 32'(busy), 32'd1);
    chk("id_state_run", 32'(o_dbg_state), 32'd1);
    issue_cyc = cyc;
    wait_done("id", 60);
    tick(3);
    check_writes("id");
    if (wc_q.size() == NPIX) begin
      chk("id_first_write_latency", 32'(wc_q[0] - issue_cyc), 32'd3);
      chk("id_done_after_last_write", 32'(done_cyc - wc_q[NPIX-1]), 32'd1);
    end else begin
      chk("id_write_log_complete", 32'(wc_q.size()), 32'(NPIX));
    end
    chk("id_done_count", 32'(done_cnt), 32'd1);

    // kernels
    run_frame("gauss_uni",   2'd1, 1'b0, 12'h888, 12'h888, 12'h888, 12'h888);
    run_frame("gauss_ctr",   2'd1, 1'b0, 12'h8F0, 12'h000, 12'h230, 12'h8F0);
    run_frame("sharp_clamp", 2'd2, 1'b0, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF);
    run_frame("sharp_neg",   2'd2, 1'b0, 12'h123, 12'h321, SHARP_NEG, 12'h123);
    run_frame("edge",        2'd3, 1'b0, 12'h000, 12'hFFF, EDGE_INT, 12'h000);
    run_frame("pass",        2'd3, 1'b1, 12'h123, 12'h321, 12'h123, 12'h123);

    // hold for 5 cycles mid-frame, then a start pulse while busy
    win_mode = 0;
    build_exp_id();
    clear_mon();
    @(negedge sys_clk);
    kernel_sel = 2'd0;
    pass_thru = 1'b0;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    tick(3);
    h = raddr_alu;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      #1;
      chk($sformatf("hold_wen_low%0d", i), 32'(wen_alu), 32'd0);
      chk($sformatf("hold_raddr_frozen%0d", i), 32'(raddr_alu), 32'(h));
    end
    hold = 1'b0;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    #1;
    chk("hold_busy_during_restart", 32'(busy), 32'd1);
    wait_done("hold", 60);
    tick(8);
    check_writes("hold");
    chk("hold_done_count", 32'(done_cnt), 32'd1);
    chk("hold_idle_after", 32'(busy), 32'd0);

    // asynchronous reset mid-frame
    win_mode = 0;
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    tick(5);
    #1;
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_raddr", 32'(raddr_alu), 32'd0);
    chk("mid_rst_waddr", 32'(waddr_alu), 32'd0);
    chk("mid_rst_wdata", 32'(wdata_alu), 32'd0);
    chk("mid_rst_wen", 32'(wen_alu), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    clear_mon();
    tick(20);
    #1;
    chk("post_rst_no_writes", 32'(wa_q.size()), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_state", 32'(o_dbg_state), 32'd0);

    // a fresh start works after the abandoned frame
    run_frame("recover", 2'd1, 1'b0, 12'h888, 12'h888, 12'h888, 12'h888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
